// File: rtl/bin2x2_filter.sv
// 2x2 binning of a raster pixel stream into rounded-average pixels; result registered 1 cycle after the 4th pixel.
// Backpressure: in_ready drops while a result is held unaccepted, so input stalls and nothing is lost.
module bin2x2_filter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int PW   = PIXEL_BIT_WIDTH;
  localparam int HALF = IN_COLS / 2;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int XW   = LW + 1;
  localparam int YW   = $clog2(IN_ROWS);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] held_q, held_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic [PW:0]   linebuf_q [HALF];

  logic          accept, x_end, y_end, lb_we, load;
  logic [LW-1:0] lb_idx;
  logic [PW:0]   lb_rd, pair_sum;
  logic [PW+1:0] blk_sum, rnd_sum;

  assign in_ready  = !vld_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign x_end     = (x_q == XW'(IN_COLS - 1));
  assign y_end     = (y_q == YW'(IN_ROWS - 1));
  assign lb_idx    = x_q[XW-1:1];
  assign lb_rd     = linebuf_q[lb_idx];
  assign pair_sum  = {1'b0, held_q} + {1'b0, pixel_in};
  assign blk_sum   = {1'b0, lb_rd} + {1'b0, pair_sum};
  // Max block sum plus rounding bias still fits, so the shifted result never wraps.
  assign rnd_sum   = blk_sum + (PW+2)'(2);

  assign pixel_out = pix_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    held_d = held_q;
    lb_we  = 1'b0;
    load   = 1'b0;
    if (accept) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (!x_q[0])      held_d = pixel_in;
      else if (!y_q[0]) lb_we  = 1'b1;
      else              load   = 1'b1;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    pix_d  = pix_q;
    last_d = last_q;
    if (load) begin
      vld_d  = 1'b1;
      pix_d  = rnd_sum[PW+1:2];
      last_d = x_end && y_end;
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      held_q <= '0;
      pix_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      held_q <= held_d;
      pix_q  <= pix_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Row 0 of each frame rewrites every entry before row 1 reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= pair_sum;
  end

endmodule

// File: tb/tb_bin2x2_filter.sv
// Scoreboard bench for bin2x2_filter on a 4x4 frame: model computes block averages from the pixels it sent.
module tb_bin2x2_filter;
  localparam int PW = 12;
  localparam int R  = 4;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] pixel_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  bin2x2_filter #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(R), .IN_COLS(C)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int pix; int last; int cyc; } exp_t;
  exp_t sbq[$];
  int   got_pix[$];
  int   got_last[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   mx = 0, my = 0;
  int   fr[R][C];
  bit   front_seen = 0, stall_prev = 0;
  int   stall_pix = 0;
  int   e4[4] = '{4, 6, 12, 14};

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input int pix);
    int s;
    exp_t e;
    fr[my][mx] = pix;
    if ((mx % 2 == 1) && (my % 2 == 1)) begin
      s = fr[my-1][mx-1] + fr[my-1][mx] + fr[my][mx-1] + pix;
      e.pix  = (s + 2) / 4;
      e.last = (mx == C-1 && my == R-1) ? 1 : 0;
      e.cyc  = cyc;
      sbq.push_back(e);
    end
    if (mx == C-1) begin
      mx = 0;
      my = (my == R-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic step(input bit vld, input int pix, input bit ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = vld;
    pixel_in  = PW'(pix);
    out_ready = ordy;
    #1;
    cyc++;
    if (stall_prev) begin
      check_eq("hold_vld", out_valid, 1);
      check_eq("hold_pix", pixel_out, stall_pix);
    end
    stall_prev = out_valid && !out_ready;
    stall_pix  = pixel_out;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        if (!front_seen) begin
          check_eq("latency", cyc, sbq[0].cyc + 1);
          front_seen = 1;
        end
        if (out_ready) begin
          e = sbq.pop_front();
          check_eq("pix_out", pixel_out, e.pix);
          check_eq("out_last", out_last, e.last);
          got_pix.push_back(pixel_out);
          got_last.push_back(out_last);
          front_seen = 0;
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) model_accept(pix);
  endtask

  task automatic send(input int pix, input bit ordy);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    while (!acc && k < 50) begin
      step(1'b1, pix, ordy, acc);
      k++;
    end
    if (!acc) check_eq("send_timeout", in_ready, 1);
  endtask

  task automatic drain();
    bit acc;
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      step(1'b0, 0, 1'b1, acc);
      k++;
    end
    if (sbq.size() > 0) check_eq("drain_timeout", sbq.size(), 0);
    step(1'b0, 0, 1'b1, acc);
  endtask

  task automatic check_got4(input string tag);
    check_eq({tag, "_n"}, got_pix.size(), 4);
    for (int i = 0; i < 4 && i < got_pix.size(); i++) begin
      check_eq({tag, "_val"}, got_pix[i], e4[i]);
      check_eq({tag, "_last"}, got_last[i], (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    bit acc;
    int n_acc;
    int rp[16];

    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_pixel_out", pixel_out, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame at full rate, also counts accepted pixels per cycle.
    got_pix.delete(); got_last.delete();
    n_acc = 0;
    for (int p = 1; p <= 16; p++) begin
      step(1'b1, p, 1'b1, acc);
      if (acc) n_acc++;
    end
    check_eq("full_rate_acc", n_acc, 16);
    drain();
    check_got4("basic");

    // Rounding and no-wrap blocks; fourth block random.
    rp = '{1, 1, 1, 1, 1, 2, 2, 2, 4095, 4095, 0, 0, 4095, 4095, 0, 0};
    for (int i = 0; i < 4; i++) begin
      rp[10 + (i / 2) * 4 + (i % 2)] = int'($urandom_range(0, 4095));
    end
    got_pix.delete(); got_last.delete();
    for (int p = 0; p < 16; p++) send(rp[p], 1'b1);
    drain();
    check_eq("round_n", got_pix.size(), 4);
    if (got_pix.size() >= 3) begin
      check_eq("round_1112", got_pix[0], 1);
      check_eq("round_1122", got_pix[1], 2);
      check_eq("round_max", got_pix[2], 4095);
    end

    // Backpressure after first output.
    got_pix.delete(); got_last.delete();
    for (int p = 1; p <= 6; p++) send(p, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 7, 1'b0, acc);
      if (i > 0) begin
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_pix", pixel_out, 4);
        check_eq("bp_acc", acc, 0);
      end
    end
    for (int p = 7; p <= 16; p++) send(p, 1'b1);
    drain();
    check_got4("bp");

    // Gapped input.
    got_pix.delete(); got_last.delete();
    for (int p = 1; p <= 16; p++) begin
      step(1'b0, 99, 1'b1, acc);
      send(p, 1'b1);
    end
    drain();
    check_got4("gap");

    // Two frames back to back.
    got_pix.delete(); got_last.delete();
    for (int p = 0; p < 32; p++) send((p % 16) + 1, 1'b1);
    drain();
    check_eq("b2b_n", got_pix.size(), 8);
    if (got_pix.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("b2b_repeat", got_pix[i+4], e4[i]);
        check_eq("b2b_last", got_last[i+4], got_last[i]);
      end
      check_eq("b2b_last4", got_last[3], 1);
      check_eq("b2b_last8", got_last[7], 1);
    end

    // Asynchronous reset mid row 1 with a pending output.
    for (int p = 1; p <= 6; p++) send(p, 1'b1);
    step(1'b0, 0, 1'b0, acc);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_last", out_last, 0);
    check_eq("arst_pixel_out", pixel_out, 0);
    sbq.delete();
    mx = 0; my = 0;
    front_seen = 0; stall_prev = 0;
    @(negedge clk);
    reset = 1'b1;
    got_pix.delete(); got_last.delete();
    for (int p = 1; p <= 16; p++) send(p, 1'b1);
    drain();
    check_got4("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2x2_filter.md
Name: bin2x2_filter

Overview:
- Downstream consumer of the crop filter's pixel stream.
- Performs 2x2 binning: each non-overlapping 2x2 block of the cropped IN_ROWS x IN_COLS raster-order frame becomes one rounded-average pixel, giving an (IN_ROWS/2) x (IN_COLS/2) output frame.
- Uses a half-line buffer of horizontal pair sums and a one-entry output register with valid/ready handshake.

Parameters:
- PIXEL_BIT_WIDTH, 12, bits per pixel in and out.
- IN_ROWS, 20, rows per input frame. Must be even and >= 2.
- IN_COLS, 20, columns per input frame. Must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel, raster order.
- in_valid  input  1  pixel_in is valid.
- in_ready  output  1  block accepts pixel_in this cycle.
- pixel_out  output  PIXEL_BIT_WIDTH  binned pixel.
- out_valid  output  1  pixel_out is valid.
- out_ready  input  1  downstream accepts pixel_out.
- out_last  output  1  qualifies pixel_out as the final binned pixel of the frame.

Behaviour:
- Reset (reset=0, async):
  - x=0, y=0, out_valid=0, pixel_out=0, out_last=0, held-pixel register=0.
  - Line buffer is not reset; row 0 of every frame overwrites it before it is read.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A pixel is accepted when in_valid && in_ready.
  - Nothing advances on cycles without acceptance.
- Position counters:
  - x counts 0..IN_COLS-1 and y counts 0..IN_ROWS-1, advancing on each accepted pixel.
  - At x=IN_COLS-1: x->0 and y increments.
  - At x=IN_COLS-1 and y=IN_ROWS-1: x->0 and y->0, so the next frame starts automatically.
- Even row (y[0]=0):
  - Even x: pixel stored in held register.
  - Odd x: linebuf[x>>1] <= held + pixel_in, width PIXEL_BIT_WIDTH+1.
  - No output produced.
- Odd row (y[0]=1):
  - Even x: pixel stored in held register.
  - Odd x: sum = linebuf[x>>1] + held + pixel_in, width PIXEL_BIT_WIDTH+2.
  - pixel_out <= (sum + 2) >> 2, i.e. round-half-up.
  - No overflow or saturation is needed: the maximum result equals 2^PIXEL_BIT_WIDTH-1.
  - out_valid <= 1.
  - out_last <= (x==IN_COLS-1 && y==IN_ROWS-1).
- Output register:
  - Latency is 1 cycle from acceptance of an odd-row, odd-column pixel to out_valid.
  - out_valid clears on out_valid && out_ready unless a new result loads the same cycle; a new result has priority.
  - While out_valid && !out_ready: pixel_out and out_last hold stable and in_ready=0.
- Line buffer: IN_COLS/2 entries of PIXEL_BIT_WIDTH+1 bits, read and written at index x>>1.
- Output count: exactly (IN_ROWS/2)*(IN_COLS/2) outputs per frame, with out_last asserted only on the last one.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0). A pending output is dropped.
- Full-rate throughput: with in_valid=1 and out_ready=1 every cycle, one pixel is accepted per cycle and there are no bubbles.

Test Plan:
- IN_ROWS=4, IN_COLS=4, pixels 1..16 raster, out_ready=1 -> outputs 4, 6, 12, 14, with out_last=1 only on 14. Each output appears 1 cycle after pixels 6, 8, 14, 16 respectively.
- Rounding: 2x2 block {1,1,1,2} -> 1. Block {1,1,2,2} -> 2. All 4095 (12-bit) -> 4095, no wrap.
- Backpressure: hold out_ready=0 after the first output -> in_ready=0 and pixel_out stays 4 with no pixel lost. Release -> output sequence continues 6, 12, 14 with no data loss.
- Gapped input: in_valid toggles 1/0 each cycle -> same outputs 4, 6, 12, 14. Counters do not advance on idle cycles.
- Back-to-back frames: send 32 pixels (two 4x4 frames) continuously -> 8 outputs, out_last on the 4th and 8th, and the second frame's results are identical to the first.
- Reset: assert reset=0 asynchronously mid-row 1 with out_valid=1 -> out_valid=0 immediately. After release, a fresh 1..16 frame yields 4, 6, 12, 14.
